alu_seq_ctrl: RTL and testbench

Sequencer in front of the 8-bit arithmetic cells. It accepts one operation at a time over a valid/ready request port and dispatches ADD/SUB/MUL/CMP to the combinational cells. DIV runs through an iterative 8-cycle serial divider. The result is held on a valid/ready response port until it is consumed. It sits between the instruction decode/front end and the Sum/Minus/Multiply cells, and gives a single point of issue and backpressure.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_cells.sv | 24 ++
 rtl/div_seq.sv | 58 +++++
 rtl/alu_seq_ctrl.sv | 115 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcodes and sequencer state encoding for the ALU sequencer slice.
package alu_pkg;
   localparam int WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_CMP = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/alu_cells.sv
// Fixed 8-bit combinational arithmetic cells shared by the sequencer.
module Sum_cell (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);
   assign y = a + b;
endmodule

module Minus_cell (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);
   assign y = a - b;
endmodule

module Multiply_cell (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] y
);
   assign y = a * b;
endmodule

// File: rtl/div_seq.sv
// Serial restoring divider: one quotient bit per clock after start.
module div_seq #(
   parameter int WIDTH = 8,
   parameter int ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = $clog2(ITERS);

   logic [WIDTH:0]   r, r_sh, r_nxt;
   logic [WIDTH-1:0] q, q_nxt, d;
   logic [CW-1:0]    cnt;
   logic             run;

   always_comb begin
      r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
      q_nxt = {q[WIDTH-2:0], 1'b0};
      r_nxt = r_sh;
      if (r_sh >= {1'b0, d}) begin
         r_nxt    = r_sh - {1'b0, d};
         q_nxt[0] = 1'b1;
      end
   end

   // Results are the final iteration's next values, so the owner can capture
   // them on the same edge that done is seen.
   assign done      = run && (cnt == CW'(ITERS-1));
   assign quotient  = q_nxt;
   assign remainder = r_nxt[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r   <= '0;
         q   <= '0;
         d   <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         r   <= '0;
         q   <= a;
         d   <= b;
         cnt <= '0;
         run <= 1'b1;
      end else if (run) begin
         r   <= r_nxt;
         q   <= q_nxt;
         cnt <= cnt + 1'b1;
         if (done) run <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Single-issue sequencer: dispatches ops to the 8-bit cells or the serial
// divider and holds the result on a valid/ready response port.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH     = alu_pkg::WIDTH,
   parameter int DIV_ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_lo,
   output logic [WIDTH-1:0] rsp_hi,
   output logic             rsp_flag,
   output logic             busy
);
   state_t state, state_nxt;

   logic             accept, div_go, div_done;
   logic [WIDTH-1:0] add_y, sub_y, div_q, div_r;
   logic [2*WIDTH-1:0] mul_y;
   logic [WIDTH-1:0] res_lo, res_hi, nxt_lo, nxt_hi;
   logic             res_flag, nxt_flag;

   Sum_cell      u_sum (.a(req_a), .b(req_b), .y(add_y));
   Minus_cell    u_sub (.a(req_a), .b(req_b), .y(sub_y));
   Multiply_cell u_mul (.a(req_a), .b(req_b), .y(mul_y));

   assign accept = req_valid && req_ready;
   assign div_go = accept && (req_op == OP_DIV) && (req_b != '0);

   div_seq #(.WIDTH(WIDTH), .ITERS(DIV_ITERS)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_go),
      .a        (req_a),
      .b        (req_b),
      .done     (div_done),
      .quotient (div_q),
      .remainder(div_r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = div_go ? DIV : DONE;
         DIV:     if (div_done)  state_nxt = DONE;
         DONE:    if (rsp_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Single-cycle result; DIV by zero lands in the default flag-only path.
   always_comb begin
      nxt_lo   = '0;
      nxt_hi   = '0;
      nxt_flag = 1'b1;
      case (req_op)
         OP_ADD: begin
            nxt_lo   = add_y;
            nxt_flag = ({1'b0, req_a} + {1'b0, req_b}) > (WIDTH+1)'((1 << WIDTH) - 1);
         end
         OP_SUB: begin
            nxt_lo   = sub_y;
            nxt_flag = req_a < req_b;
         end
         OP_MUL: begin
            {nxt_hi, nxt_lo} = mul_y;
            nxt_flag         = mul_y[2*WIDTH-1:WIDTH] != '0;
         end
         OP_CMP: begin
            nxt_lo   = {{(WIDTH-1){1'b0}}, req_a == req_b};
            nxt_flag = req_a == req_b;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_lo   <= '0;
         res_hi   <= '0;
         res_flag <= 1'b0;
      end else if (accept && !div_go) begin
         res_lo   <= nxt_lo;
         res_hi   <= nxt_hi;
         res_flag <= nxt_flag;
      end else if (div_done) begin
         res_lo   <= div_q;
         res_hi   <= div_r;
         res_flag <= 1'b0;
      end
   end

   assign rsp_lo   = res_lo;
   assign rsp_hi   = res_hi;
   assign rsp_flag = res_flag;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and swept checks of the ALU sequencer against hand values.
module tb_alu_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_ready;
   logic [2:0] req_op = 3'd0;
   logic [7:0] req_a = 8'd0, req_b = 8'd0;
   logic       rsp_valid, rsp_ready = 1'b0;
   logic [7:0] rsp_lo, rsp_hi;
   logic       rsp_flag, busy;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_flag(rsp_flag), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] division_cell(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] q, r;
      q = a / b;
      r = a % b;
      return {r, q};
   endfunction

   // Accept happens on the posedge between the two negedges.
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(negedge clk);
      req_valid = 1'b0; req_op = 3'd7; req_a = ~a; req_b = ~b;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] elo, input logic [7:0] ehi,
                         input logic ef, input int elat, input bit chk_busy);
      int lat;
      bit seen;
      issue(op, a, b);
      lat = 1; seen = 0;
      while (!seen && lat <= 20) begin
         if (chk_busy) chk({tag, ".busy"}, busy, 1);
         if (rsp_valid) seen = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      chk({tag, ".lat"}, lat, elat);
      chk({tag, ".lo"}, rsp_lo, elo);
      chk({tag, ".hi"}, rsp_hi, ehi);
      chk({tag, ".flag"}, rsp_flag, ef);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, ".idle"}, busy, 0);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic [15:0] ref_qr;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.valid", rsp_valid, 0);
      chk("rst.out", {rsp_hi, rsp_lo, 7'd0, rsp_flag}, 0);
      chk("rst.busy", busy, 0);
      chk("rst.ready", req_ready, 1);
      rst_n = 1'b1;

      // Reset while DONE, held 3 cycles
      issue(3'd2, 8'hFF, 8'hFF);
      chk("pre_rst.valid", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_done.valid", rsp_valid, 0);
      repeat (3) @(negedge clk);
      chk("rst_done.out", {rsp_hi, rsp_lo, 7'd0, rsp_flag}, 0);
      chk("rst_done.busy", busy, 0);
      chk("rst_done.ready", req_ready, 1);
      rst_n = 1'b1;
      run_op("add1", 3'd0, 8'd1, 8'd1, 8'h02, 8'h00, 0, 1, 1);

      // Single-cycle ops
      run_op("add_c",   3'd0, 8'd200, 8'd100, 8'h2C, 8'h00, 1, 1, 1);
      run_op("add_wrap",3'd0, 8'hFF,  8'h01,  8'h00, 8'h00, 1, 1, 0);
      run_op("sub_b",   3'd1, 8'd3,   8'd5,   8'hFE, 8'h00, 1, 1, 1);
      run_op("sub_nb",  3'd1, 8'd5,   8'd3,   8'h02, 8'h00, 0, 1, 0);
      run_op("cmp_eq",  3'd4, 8'h5A,  8'h5A,  8'h01, 8'h00, 1, 1, 1);
      run_op("cmp_ne",  3'd4, 8'h01,  8'h02,  8'h00, 8'h00, 0, 1, 0);
      run_op("mul_max", 3'd2, 8'hFF,  8'hFF,  8'h01, 8'hFE, 1, 1, 1);
      run_op("mul_0",   3'd2, 8'h12,  8'h00,  8'h00, 8'h00, 0, 1, 0);
      run_op("mul_lo",  3'd2, 8'h0F,  8'h11,  8'hFF, 8'h00, 0, 1, 0);

      // Divider
      run_op("div200_7", 3'd3, 8'd200, 8'd7,   8'h1C, 8'h04, 0, 9, 1);
      run_op("div255_1", 3'd3, 8'd255, 8'd1,   8'hFF, 8'h00, 0, 9, 0);
      run_op("div7_200", 3'd3, 8'd7,   8'd200, 8'h00, 8'h07, 0, 9, 0);
      run_op("div_zero", 3'd3, 8'd5,   8'd0,   8'h00, 8'h00, 1, 1, 1);
      run_op("ill7",     3'd7, 8'h33,  8'h44,  8'h00, 8'h00, 1, 1, 1);
      run_op("ill5",     3'd5, 8'h01,  8'h01,  8'h00, 8'h00, 1, 1, 0);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(255));
         rb = 8'($urandom_range(255, 1));
         ref_qr = division_cell(ra, rb);
         run_op($sformatf("sweep%0d", i), 3'd3, ra, rb, ref_qr[7:0], ref_qr[15:8], 0, 9, 0);
      end

      // Backpressure: MUL 0x10*0x10 = 0x0100 held while rsp_ready low
      issue(3'd2, 8'h10, 8'h10);
      chk("bp.valid", rsp_valid, 1);
      for (int c = 0; c < 5; c++) begin
         chk("bp.lo", rsp_lo, 8'h00);
         chk("bp.hi", rsp_hi, 8'h01);
         chk("bp.flag", rsp_flag, 1);
         chk("bp.ready", req_ready, 0);
         chk("bp.busy", busy, 1);
         chk("bp.hold", rsp_valid, 1);
         if (c == 1) begin
            req_valid = 1'b1; req_op = 3'd0; req_a = 8'h01; req_b = 8'h02;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp.idle", busy, 0);
      chk("bp.novalid", rsp_valid, 0);
      @(negedge clk);
      chk("bp.no_ghost", rsp_valid, 0);

      // Reset during DIV iteration 4, then a clean DIV
      issue(3'd3, 8'd200, 8'd7);
      repeat (3) @(negedge clk);
      chk("abort.busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", busy, 0);
      chk("abort.ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         chk("abort.no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      run_op("div_after", 3'd3, 8'd200, 8'd7, 8'h1C, 8'h04, 0, 9, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
